// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the cache-to-memory line-port arbiter.
package cache_arb_pkg;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        TURN    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mux2to1.sv
// Generic two-input multiplexer used for response steering.
module mux2to1 #(
    parameter int W = 1
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates one physical-memory line port between icache and dcache.
// Define CACHE_ARB_RR_EN for round-robin tie-breaking; otherwise dcache wins ties.
module cache_arbiter #(
    parameter int LINE_W = cache_arb_pkg::LINE_W,
    parameter int ADDR_W = cache_arb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    import cache_arb_pkg::*;

    arb_state_t state_r;
    logic       want_i_s;
    logic       want_d_s;
    logic       grant_i_s;
    logic       grant_d_s;
    logic       serve_i_s;
    logic       serve_d_s;
`ifdef CACHE_ARB_RR_EN
    logic       last_d_r;
`endif

    // Pick a winner among the requests currently presented
    always_comb begin
        want_i_s  = i_read;
        want_d_s  = d_read | d_write;
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (want_i_s && want_d_s) begin
`ifdef CACHE_ARB_RR_EN
            grant_d_s = ~last_d_r;
`else
            grant_d_s = 1'b1;
`endif
            grant_i_s = ~grant_d_s;
        end else begin
            grant_i_s = want_i_s;
            grant_d_s = want_d_s;
        end
    end

    // Arbitration FSM; the memory command is captured at grant and held until pmem_resp
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= {ADDR_W{1'b0}};
            pmem_wdata   <= {LINE_W{1'b0}};
`ifdef CACHE_ARB_RR_EN
            last_d_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_d_s) begin
                        // A write-back wins over a simultaneous (illegal) read
                        pmem_address <= d_address;
                        pmem_wdata   <= d_wdata;
                        pmem_write   <= d_write;
                        pmem_read    <= ~d_write;
                        state_r      <= SERVE_D;
`ifdef CACHE_ARB_RR_EN
                        last_d_r     <= 1'b1;
`endif
                    end else if (grant_i_s) begin
                        pmem_address <= i_address;
                        pmem_wdata   <= {LINE_W{1'b0}};
                        pmem_write   <= 1'b0;
                        pmem_read    <= 1'b1;
                        state_r      <= SERVE_I;
`ifdef CACHE_ARB_RR_EN
                        last_d_r     <= 1'b0;
`endif
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        state_r    <= TURN;
                    end else begin
                        state_r    <= state_r;
                    end
                end
                TURN: begin
                    state_r <= IDLE;
                end
                default: begin
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    // A reset in the response cycle aborts the transaction without a resp
    assign serve_i_s = (state_r == SERVE_I) & ~rst;
    assign serve_d_s = (state_r == SERVE_D) & ~rst;

    mux2to1 #(.W(1)) u_i_resp_mux (
        .sel (serve_i_s),
        .a   (1'b0),
        .b   (pmem_resp),
        .y   (i_resp)
    );

    mux2to1 #(.W(1)) u_d_resp_mux (
        .sel (serve_d_s),
        .a   (1'b0),
        .b   (pmem_resp),
        .y   (d_resp)
    );

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule
